// File: rtl/rf_wb_pkg.sv
// Shared types for the regfile writeback arbiter: index width, halt FSM states,
// and the writeback request record.
package rf_wb_pkg;

    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0]    rd_num;
        logic [XLEN_DEFAULT-1:0] rd_data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational round-robin arbiter: the first asserted request at or above ptr
// (modulo NREQ) is granted.
module rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    always_comb begin
        logic        w_found;
        int unsigned w_idx;
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = (32'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin sharing of the regfile write port with a registered write stage and
// halt drain sequencing. Optional counters are built when RF_WB_STATS_EN is defined.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 3
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*REG_IDX_W-1:0] req_rd_num,
    input  logic [NREQ*XLEN-1:0]      req_rd_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      halt_req,
    output logic                      rd_we,
    output logic [REG_IDX_W-1:0]      rd_num,
    output logic [XLEN-1:0]           rd_data,
    output logic                      halted,
    output logic                      can_print
`ifdef RF_WB_STATS_EN
    ,
    output logic [NREQ*32-1:0]        stat_grant,
    output logic [31:0]               stat_conflict
`endif
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [PTR_W-1:0]       w_gnt_idx;
    logic [NREQ-1:0]        w_gnt;
    logic                   w_xfer;
    logic [REG_IDX_W-1:0]   w_sel_num;
    logic [XLEN-1:0]        w_sel_data;
    logic                   r_rd_we;
    logic [REG_IDX_W-1:0]   r_rd_num;
    logic [XLEN-1:0]        r_rd_data;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    assign req_ready = (r_state == DONE) ? '0 : w_gnt;

    always_comb begin
        w_xfer     = |req_ready;
        w_gnt_idx  = '0;
        w_sel_num  = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                w_gnt_idx  = PTR_W'(i);
                w_sel_num  = req_rd_num[i*REG_IDX_W +: REG_IDX_W];
                w_sel_data = req_rd_data[i*XLEN +: XLEN];
            end
        end
        w_ptr_next = (w_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN:     if (halt_req) w_state_next = DRAIN;
            // Drain completes once no requester is waiting and nothing is in flight.
            DRAIN:   if (req_valid == '0 && !r_rd_we) w_state_next = DONE;
            DONE:    w_state_next = DONE;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= RUN;
            r_ptr     <= '0;
            r_rd_we   <= 1'b0;
            r_rd_num  <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer) begin
                r_ptr     <= w_ptr_next;
                r_rd_we   <= (w_sel_num != '0);
                r_rd_num  <= w_sel_num;
                r_rd_data <= w_sel_data;
            end else begin
                r_rd_we <= 1'b0;
            end
        end
    end

    assign rd_we     = r_rd_we;
    assign rd_num    = r_rd_num;
    assign rd_data   = r_rd_data;
    assign halted    = (r_state == DONE);
    assign can_print = (r_state == DONE);

`ifdef RF_WB_STATS_EN
    logic [NREQ*32-1:0] r_stat_grant;
    logic [31:0]        r_stat_conflict;
    logic               w_conflict;

    always_comb begin
        int unsigned w_nvalid;
        w_nvalid = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_nvalid = w_nvalid + 32'(req_valid[i]);
        end
        w_conflict = (w_nvalid >= 2) && (r_state != DONE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_stat_grant    <= '0;
            r_stat_conflict <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    r_stat_grant[i*32 +: 32] <= r_stat_grant[i*32 +: 32] + 32'd1;
                end
            end
            if (w_conflict) begin
                r_stat_conflict <= r_stat_conflict + 32'd1;
            end
            if (r_state != DONE && w_state_next == DONE) begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    $display("rf_wb_arbiter stats: grant[%0d]=%0d", i, r_stat_grant[i*32 +: 32]);
                end
                $display("rf_wb_arbiter stats: conflict=%0d", r_stat_conflict);
            end
        end
    end

    assign stat_grant    = r_stat_grant;
    assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (also covers RF_WB_STATS_EN builds).
module tb_rf_wb_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREQ = 3;

    logic                  clk;
    logic                  rst_b;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*5-1:0]     req_rd_num;
    logic [NREQ*XLEN-1:0]  req_rd_data;
    logic [NREQ-1:0]       req_ready;
    logic                  halt_req;
    logic                  rd_we;
    logic [4:0]            rd_num;
    logic [XLEN-1:0]       rd_data;
    logic                  halted;
    logic                  can_print;
`ifdef RF_WB_STATS_EN
    logic [NREQ*32-1:0]    stat_grant;
    logic [31:0]           stat_conflict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [XLEN-1:0] rf [32] = '{default: '0};

    rf_wb_arbiter #(
        .XLEN (XLEN),
        .NREQ (NREQ)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_valid   (req_valid),
        .req_rd_num  (req_rd_num),
        .req_rd_data (req_rd_data),
        .req_ready   (req_ready),
        .halt_req    (halt_req),
        .rd_we       (rd_we),
        .rd_num      (rd_num),
        .rd_data     (rd_data),
        .halted      (halted),
        .can_print   (can_print)
`ifdef RF_WB_STATS_EN
        ,
        .stat_grant    (stat_grant),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model fed by the write port.
    always @(posedge clk) begin
        if (rd_we) rf[rd_num] <= rd_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] num, input logic [XLEN-1:0] data);
        req_rd_num[i*5 +: 5]        = num;
        req_rd_data[i*XLEN +: XLEN] = data;
    endtask

    initial begin
        req_valid   = '0;
        req_rd_num  = '0;
        req_rd_data = '0;
        halt_req    = 1'b0;
        rst_b       = 1'b0;
        #3;
        check_eq("rst_rd_we", 64'(rd_we), 64'd0);
        check_eq("rst_rd_num", 64'(rd_num), 64'd0);
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);
        check_eq("rst_halted", 64'(halted), 64'd0);
        check_eq("rst_can_print", 64'(can_print), 64'd0);
        step();
        rst_b = 1'b1;
        step();

        // Contention: all three valid for six grants, pointer starting at 0.
        set_req(0, 5'd1, 32'h100);
        set_req(1, 5'd2, 32'h200);
        set_req(2, 5'd3, 32'h300);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("cont_ready_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            step();
            check_eq($sformatf("cont_we_%0d", k), 64'(rd_we), 64'd1);
            check_eq($sformatf("cont_num_%0d", k), 64'(rd_num), 64'((k % 3) + 1));
            check_eq($sformatf("cont_data_%0d", k), 64'(rd_data), 64'(((k % 3) + 1) * 256));
            if (k == 5) req_valid = '0;
        end
        step();
        check_eq("cont_we_off", 64'(rd_we), 64'd0);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        for (int t = 0; t < 10 && !halted; t++) step();
        check_eq("cont_halted", 64'(halted), 64'd1);
`ifdef RF_WB_STATS_EN
        check_eq("stat_grant0", 64'(stat_grant[31:0]), 64'd2);
        check_eq("stat_grant1", 64'(stat_grant[63:32]), 64'd2);
        check_eq("stat_grant2", 64'(stat_grant[95:64]), 64'd2);
        check_eq("stat_conflict", 64'(stat_conflict), 64'd6);
`endif
        req_valid = 3'b111;
        #1;
        check_eq("done_ready", 64'(req_ready), 64'd0);
        req_valid = '0;

        rst_b = 1'b0;
        step();
        rst_b = 1'b1;

        // Single write to r5.
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        check_eq("single_ready", 64'(req_ready), 64'b001);
        step();
        check_eq("single_we", 64'(rd_we), 64'd1);
        check_eq("single_num", 64'(rd_num), 64'd5);
        check_eq("single_data", 64'(rd_data), 64'hDEADBEEF);
        req_valid = '0;
        step();
        check_eq("single_rf5", 64'(rf[5]), 64'hDEADBEEF);

        // r0 write is accepted but does not assert the write enable.
        set_req(1, 5'd0, 32'h1234);
        req_valid = 3'b010;
        #1;
        check_eq("r0_ready", 64'(req_ready), 64'b010);
        step();
        check_eq("r0_we", 64'(rd_we), 64'd0);
        check_eq("r0_num", 64'(rd_num), 64'd0);
        check_eq("r0_data", 64'(rd_data), 64'h1234);
        req_valid = '0;
        step();
        check_eq("r0_rf0", 64'(rf[0]), 64'd0);

        // Same destination from req0 and req2 with pointer at 2: req2 first, req0 wins.
        set_req(0, 5'd9, 32'hA);
        set_req(2, 5'd9, 32'hC);
        req_valid = 3'b101;
        #1;
        check_eq("same_ready_a", 64'(req_ready), 64'b100);
        step();
        check_eq("same_data_a", 64'(rd_data), 64'hC);
        req_valid = 3'b001;
        #1;
        check_eq("same_ready_b", 64'(req_ready), 64'b001);
        step();
        check_eq("same_data_b", 64'(rd_data), 64'hA);
        req_valid = '0;
        step();
        check_eq("same_rf9", 64'(rf[9]), 64'hA);

        // Drain: req2 with halt pulse, req0 one cycle later.
        set_req(2, 5'd7, 32'h55);
        req_valid = 3'b100;
        halt_req  = 1'b1;
        #1;
        check_eq("drain_ready_a", 64'(req_ready), 64'b100);
        step();
        halt_req  = 1'b0;
        set_req(0, 5'd8, 32'h66);
        req_valid = 3'b001;
        #1;
        check_eq("drain_ready_b", 64'(req_ready), 64'b001);
        check_eq("drain_num_a", 64'(rd_num), 64'd7);
        step();
        req_valid = '0;
        check_eq("drain_we_b", 64'(rd_we), 64'd1);
        check_eq("drain_num_b", 64'(rd_num), 64'd8);
        check_eq("drain_halted_early", 64'(halted), 64'd0);
        step();
        check_eq("drain_we_off", 64'(rd_we), 64'd0);
        check_eq("drain_halted_pre", 64'(halted), 64'd0);
        step();
        check_eq("drain_halted", 64'(halted), 64'd1);
        check_eq("drain_can_print", 64'(can_print), 64'd1);
        check_eq("drain_rf7", 64'(rf[7]), 64'h55);
        check_eq("drain_rf8", 64'(rf[8]), 64'h66);
        req_valid = 3'b111;
        #1;
        check_eq("drain_done_ready", 64'(req_ready), 64'd0);
        req_valid = '0;

        // Asynchronous reset while in DONE.
        rst_b = 1'b0;
        #1;
        check_eq("rst_done_halted", 64'(halted), 64'd0);
        check_eq("rst_done_can_print", 64'(can_print), 64'd0);
        step();
        rst_b = 1'b1;

        // Asynchronous reset mid-DRAIN with a write in flight.
        set_req(1, 5'd4, 32'h44);
        req_valid = 3'b010;
        halt_req  = 1'b1;
        step();
        halt_req  = 1'b0;
        req_valid = '0;
        check_eq("mid_we_pre", 64'(rd_we), 64'd1);
        rst_b = 1'b0;
        #1;
        check_eq("mid_we_rst", 64'(rd_we), 64'd0);
        check_eq("mid_num_rst", 64'(rd_num), 64'd0);
        check_eq("mid_halted_rst", 64'(halted), 64'd0);
        step();
        rst_b     = 1'b1;
        req_valid = 3'b111;
        #1;
        check_eq("mid_ready_a", 64'(req_ready), 64'b001);
        step();
        check_eq("mid_ready_b", 64'(req_ready), 64'b010);
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback requesters, such as the ALU, mul/div unit and load unit.
- Uses round-robin arbitration with a valid/ready handshake. The write toward the regfile is registered.
- Also sequences end-of-simulation: on halt request it drains all pending writebacks, then asserts halted and can_print so the regfile dump reflects every retired write.

Parameters:
- XLEN, 32, data width of the regfile write data.
- NREQ, 3, number of writeback requesters (2..8).

Ports:
- clk  input  1  clock.
- rst_b  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  per-requester writeback valid.
- req_rd_num  input  NREQ*5  per-requester destination register; slice i is bits [5i+4:5i].
- req_rd_data  input  NREQ*XLEN  per-requester write data; slice i as above.
- req_ready  output  NREQ  per-requester grant/accept (one-hot or zero).
- halt_req  input  1  core requests halt; a pulse is sufficient.
- rd_we  output  1  regfile write enable.
- rd_num  output  5  regfile write index.
- rd_data  output  XLEN  regfile write data.
- halted  output  1  drain complete; level, held until reset.
- can_print  output  1  regfile dump permitted; level, held until reset.

Behaviour:
- Reset values (asynchronous): rd_we=0, rd_num=0, rd_data=0, halted=0, can_print=0, state=RUN, rr pointer=0.
- req_ready is combinational from req_valid, the rr pointer and state. At most one bit is set. It is never set for a requester whose valid is low.
- Handshake: a transfer occurs on a clock edge where req_valid[i] & req_ready[i].
  - A requester must hold valid, rd_num and data stable until accepted.
  - Dropping valid before acceptance is illegal.
- Arbitration: round-robin.
  - Priority starts at the pointer and searches upward modulo NREQ; the first valid requester is granted.
  - After a grant to i, pointer <= (i+1) mod NREQ. With no grant, the pointer holds.
- Latency: a write accepted at edge t drives rd_we=1, rd_num and rd_data during cycle t+1, i.e. it is visible in the regfile after edge t+1.
  - Throughput is one write per cycle.
  - rd_we deasserts in the cycle after an edge with no transfer.
- r0: a transfer with rd_num=0 is accepted (ready asserted) but produces rd_we=0. rd_num and rd_data still update.
- FSM states:
  - RUN: normal arbitration. halt_req=1 -> DRAIN.
  - DRAIN: arbitration continues. -> DONE when req_valid==0 and the output stage holds no pending write (rd_we==0) in the same cycle. halt_req is ignored.
  - DONE: req_ready=0 for all requesters; halted=1 and can_print=1 from the first DONE cycle. Terminal until reset. New req_valid is ignored.
- halt_req arriving in the same cycle as a transfer: the transfer completes; the state moves to DRAIN.
- Simultaneous valids on the same rd_num: serialized in rr order. The last grant wins in the regfile.
- Reset mid-DRAIN or in DONE: all state is cleared immediately; the next cycle is RUN with the pointer at 0.

Optional Feature:
- Macro: RF_WB_STATS_EN.
- When defined:
  - Adds a 32-bit grant counter per requester and a 32-bit conflict counter. The conflict counter increments in cycles with two or more valid requesters.
  - Counters wrap modulo 2^32, reset to 0 and freeze in DONE.
  - On entry to DONE, the values are printed with $display.
  - Adds output ports stat_grant (NREQ*32) and stat_conflict (32).
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package rf_wb_pkg: REG_IDX_W=5, the halt FSM state enum (RUN, DRAIN, DONE), and a wb_req_t struct (rd_num, rd_data) parameterized by XLEN through the localparam default.
- Sub-module rr_arbiter (NREQ): inputs req and ptr, output one-hot gnt. It is purely combinational.
- Pointer update, output register, FSM and stats stay in rf_wb_arbiter.

Test Plan:
- Single write: req0 valid with rd=5, data=0xDEADBEEF -> ready[0] in the same cycle; the next cycle has rd_we=1, rd_num=5, rd_data=0xDEADBEEF; regfile r5=0xDEADBEEF.
- Contention: all 3 valid continuously for 6 cycles, pointer at 0 -> grant order 0,1,2,0,1,2; rd_we high for 6 consecutive cycles.
- r0 write: req1 with rd=0, data=0x1234 -> ready[1]=1, rd_we stays 0, r0 remains 0.
- Drain: req2 valid (rd=7, data=0x55) while halt_req pulses, with req0 following one cycle later (rd=8, data=0x66) -> both writes committed; halted and can_print rise only after the final rd_we cycle; ready is all zero afterwards.
- Reset mid-DRAIN: assert rst_b=0 during DRAIN -> rd_we, halted and can_print go 0 asynchronously; after release, rr order restarts at req0.
- Stats (RF_WB_STATS_EN): run the contention scenario, then halt -> stat_grant = 2,2,2 and stat_conflict = 6.
